// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared digit constants and helpers for the MM:SS timer digits.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int              DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] MOD6_MAX   = 4'd5;
    localparam logic [DIGIT_W-1:0] ZERO_DIGIT = 4'd0;

    // Preset values above the digit's maximum clamp to the maximum.
    function automatic logic [DIGIT_W-1:0] mod6_sat(input logic [DIGIT_W-1:0] v);
        return (v > MOD6_MAX) ? MOD6_MAX : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod6_down_counter_if.sv
// ============================================================================
// Module      : mod6_down_counter_if
// Description : Control and status bundle of one mod-6 timer digit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mod6_down_counter_if;
    import timer_pkg::*;

    logic               load;
    logic               enab;
    logic [DIGIT_W-1:0] numero;
    logic [DIGIT_W-1:0] numero_saida;
    logic               tc_saida;
    logic               zero_saida;

    modport master (
        output load,
        output enab,
        output numero,
        input  numero_saida,
        input  tc_saida,
        input  zero_saida
    );

    modport slave (
        input  load,
        input  enab,
        input  numero,
        output numero_saida,
        output tc_saida,
        output zero_saida
    );

endinterface

`default_nettype wire

// File: rtl/mod6_next_state.sv
// ============================================================================
// Module      : mod6_next_state
// Description : Next-count logic of the mod-6 digit: preset, wrap, decrement.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mod6_next_state
    import timer_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] count,
    input  wire logic               load_n,
    input  wire logic               enab,
    input  wire logic [DIGIT_W-1:0] numero,
    output logic      [DIGIT_W-1:0] next_count
);

    always_comb begin
        next_count = count;
        if (!load_n) begin
            next_count = mod6_sat(numero);
        end else if (enab) begin
            // Borrow out of zero re-enters at the top of the digit range.
            next_count = (count == ZERO_DIGIT) ? MOD6_MAX : (count - 4'd1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod6_down_counter.sv
// ============================================================================
// Module      : mod6_down_counter
// Description : Tens-of-seconds BCD down counter (5..0) with borrow and zero flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mod6_down_counter
    import timer_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             clear,
    mod6_down_counter_if.slave    bus
);

    logic [DIGIT_W-1:0] r_count;
    logic [DIGIT_W-1:0] w_next_count;
    logic               w_is_zero;

    mod6_next_state u_next_state (
        .count      (r_count),
        .load_n     (bus.load),
        .enab       (bus.enab),
        .numero     (bus.numero),
        .next_count (w_next_count)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_count <= ZERO_DIGIT;
        end else begin
            r_count <= w_next_count;
        end
    end

    // Borrow is combinational so the next digit steps on the same edge as the wrap.
    assign w_is_zero        = (r_count == ZERO_DIGIT);
    assign bus.numero_saida = r_count;
    assign bus.zero_saida   = w_is_zero;
    assign bus.tc_saida     = bus.enab & w_is_zero;

endmodule

`default_nettype wire

// File: tb/tb_mod6_down_counter.sv
// ============================================================================
// Module      : tb_mod6_down_counter
// Description : Self-checking bench for the mod-6 timer digit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mod6_down_counter;

    typedef struct {
        logic       load;
        logic       enab;
        logic [3:0] numero;
        logic [3:0] exp_count;
        logic       exp_zero;
        logic       exp_tc;
    } vec_t;

    logic clk;
    logic clear;
    int   n_cmp;
    int   n_fail;
    int   model_cnt;
    vec_t vecs[19];

    mod6_down_counter_if bus();

    mod6_down_counter dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] c, input logic z, input logic t);
        check({name, "_count"}, bus.numero_saida, c);
        check({name, "_zero"}, {3'b0, bus.zero_saida}, {3'b0, z});
        check({name, "_tc"}, {3'b0, bus.tc_saida}, {3'b0, t});
    endtask

    function automatic vec_t mk(input logic l, input logic e, input logic [3:0] n,
                                input logic [3:0] c, input logic z, input logic t);
        vec_t v;
        v.load = l; v.enab = e; v.numero = n;
        v.exp_count = c; v.exp_zero = z; v.exp_tc = t;
        return v;
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Free count from 0, preset and count, saturation, load-beats-enable, hold.
        vecs[0]  = mk(1, 1, 0, 5, 0, 0);
        vecs[1]  = mk(1, 1, 0, 4, 0, 0);
        vecs[2]  = mk(1, 1, 0, 3, 0, 0);
        vecs[3]  = mk(1, 1, 0, 2, 0, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 1, 1);
        vecs[6]  = mk(1, 1, 0, 5, 0, 0);
        vecs[7]  = mk(0, 0, 3, 3, 0, 0);
        vecs[8]  = mk(1, 1, 0, 2, 0, 0);
        vecs[9]  = mk(1, 1, 0, 1, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 1, 1);
        vecs[11] = mk(0, 0, 4, 4, 0, 0);
        vecs[12] = mk(0, 0, 9, 5, 0, 0);
        vecs[13] = mk(0, 1, 2, 2, 0, 0);
        vecs[14] = mk(0, 1, 15, 5, 0, 0);
        vecs[15] = mk(0, 1, 2, 2, 0, 0);
        vecs[16] = mk(1, 0, 7, 2, 0, 0);
        vecs[17] = mk(1, 0, 7, 2, 0, 0);
        vecs[18] = mk(1, 0, 7, 2, 0, 0);

        // Reset state with no clock edge needed.
        clear      = 1'b0;
        bus.load   = 1'b1;
        bus.enab   = 1'b1;
        bus.numero = 4'd0;
        #1;
        check_outs("rst_en1", 4'd0, 1'b1, 1'b1);
        bus.enab = 1'b0;
        #1;
        check_outs("rst_en0", 4'd0, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        clear    = 1'b1;
        bus.enab = 1'b1;

        for (int i = 0; i < 19; i++) begin
            bus.load   = vecs[i].load;
            bus.enab   = vecs[i].enab;
            bus.numero = vecs[i].numero;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_zero, vecs[i].exp_tc);
        end

        // Asynchronous clear between edges, count at 2.
        #2;
        clear = 1'b0;
        #1;
        check_outs("async_clr_en0", 4'd0, 1'b1, 1'b0);
        bus.enab = 1'b1;
        #1;
        check_outs("async_clr_en1", 4'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_outs("clr_held_edge", 4'd0, 1'b1, 1'b1);

        // Cascade: borrow visible before the wrapping edge, gone after it.
        clear    = 1'b1;
        bus.load = 1'b1;
        bus.enab = 1'b1;
        #1;
        check("cascade_tc_pre", {3'b0, bus.tc_saida}, 4'd1);
        @(posedge clk);
        #1;
        check_outs("cascade_post", 4'd5, 1'b0, 1'b0);

        // Randomized run against an arithmetic reference model.
        clear = 1'b0;
        #1;
        model_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (!clear)
                model_cnt = 0;
            else if (!bus.load)
                model_cnt = (bus.numero > 4'd5) ? 5 : int'(bus.numero);
            else if (bus.enab)
                model_cnt = (model_cnt + 5) % 6;
            #1;
            check_outs("rnd", 4'(model_cnt), model_cnt == 0, bus.enab && (model_cnt == 0));

            clear      = ($urandom_range(0, 15) != 0);
            bus.load   = ($urandom_range(0, 3) != 0);
            bus.enab   = 1'($urandom_range(0, 1));
            bus.numero = 4'($urandom_range(0, 15));
            if (!clear) begin
                model_cnt = 0;
                #1;
                check_outs("rnd_async_clr", 4'd0, 1'b1, bus.enab);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
